// File: rtl/od_receiver.sv
// od_receiver: open-drain node receiver. Synchronizes the raw pulled-up net,
// debounces it with a consecutive-sample filter, and reports edges, high-pulse
// width, rejected transitions and a stuck-low condition.
module od_receiver #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned FILTER       = 3,
  parameter int unsigned WIDTH_BITS   = 8,
  parameter int unsigned STUCK_CYCLES = 200
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  node,
  input  logic                  clr,
  output logic                  level,
  output logic                  rise,
  output logic                  fall,
  output logic [WIDTH_BITS-1:0] width,
  output logic                  width_valid,
  output logic [WIDTH_BITS-1:0] glitch_cnt,
  output logic                  stuck
);

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    QUAL_HIGH = 2'd1,
    HIGH      = 2'd2,
    QUAL_LOW  = 2'd3
  } state_e;

  localparam int unsigned FCW = (FILTER < 2) ? 1 : $clog2(FILTER + 1);
  localparam int unsigned LCW = (STUCK_CYCLES < 2) ? 1 : $clog2(STUCK_CYCLES + 1);
  localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER - 1);
  localparam logic [LCW-1:0] LO_MAX    = LCW'(STUCK_CYCLES);
  localparam logic [LCW-1:0] LO_LAST   = LCW'(STUCK_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_e                 state_q;
  logic                   level_q, rise_q, fall_q, width_valid_q;
  logic [WIDTH_BITS-1:0]  width_q, hi_q;
  logic [FCW-1:0]         filt_q;
  logic [LCW-1:0]         lo_q;
  logic [WIDTH_BITS-1:0]  glitch_q, glitch_d;
  logic                   stuck_q, stuck_d;
  logic                   commit_hi, commit_lo, glitch_ev, lo_reach;

  assign s = sync_q[SYNC_STAGES-1];

  // Synchronizer chain on the raw node, idling at the pulled-up level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], node};
  end

  // Decode commits and rejected transitions from the current state and sample.
  always_comb begin
    commit_hi = 1'b0;
    commit_lo = 1'b0;
    glitch_ev = 1'b0;
    unique case (state_q)
      LOW:       commit_hi = s && (FILTER == 1);
      QUAL_HIGH: if (s) commit_hi = (filt_q == FILT_LAST); else glitch_ev = 1'b1;
      HIGH:      commit_lo = !s && (FILTER == 1);
      QUAL_LOW:  if (!s) commit_lo = (filt_q == FILT_LAST); else glitch_ev = 1'b1;
    endcase
    lo_reach = !level_q && !commit_hi && (lo_q == LO_LAST);
  end

  // Filter state machine with registered level, strobes, width and time counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HIGH;
      level_q       <= 1'b1;
      rise_q        <= 1'b0;
      fall_q        <= 1'b0;
      width_valid_q <= 1'b0;
      width_q       <= '0;
      filt_q        <= '0;
      hi_q          <= '0;
      lo_q          <= '0;
    end else begin
      rise_q        <= commit_hi;
      fall_q        <= commit_lo;
      width_valid_q <= commit_lo;
      if (commit_lo) width_q <= hi_q;

      // hi_q == 0 marks "no rise seen since reset", so a fall straight out of
      // reset reports width 0 rather than the idle-high time.
      if (commit_hi)                               hi_q <= WIDTH_BITS'(1);
      else if (level_q && hi_q != '0 && hi_q != '1) hi_q <= hi_q + 1'b1;

      if (commit_hi)                   lo_q <= '0;
      else if (!level_q && lo_q != LO_MAX) lo_q <= lo_q + 1'b1;

      unique case (state_q)
        LOW: begin
          if (commit_hi) begin
            state_q <= HIGH;
            level_q <= 1'b1;
          end else if (s) begin
            state_q <= QUAL_HIGH;
            filt_q  <= FCW'(1);
          end
        end
        QUAL_HIGH: begin
          if (commit_hi) begin
            state_q <= HIGH;
            level_q <= 1'b1;
          end else if (s) begin
            filt_q <= filt_q + 1'b1;
          end else begin
            state_q <= LOW;
          end
        end
        HIGH: begin
          if (commit_lo) begin
            state_q <= LOW;
            level_q <= 1'b0;
          end else if (!s) begin
            state_q <= QUAL_LOW;
            filt_q  <= FCW'(1);
          end
        end
        QUAL_LOW: begin
          if (commit_lo) begin
            state_q <= LOW;
            level_q <= 1'b0;
          end else if (!s) begin
            filt_q <= filt_q + 1'b1;
          end else begin
            state_q <= HIGH;
          end
        end
      endcase
    end
  end

  // Next glitch count and stuck flag; clr overrides any same-cycle update.
  always_comb begin
    glitch_d = glitch_q;
    if (glitch_ev && glitch_q != '1) glitch_d = glitch_q + 1'b1;
    if (clr) glitch_d = '0;
    stuck_d = stuck_q;
    if (commit_hi) stuck_d = 1'b0;
    if (lo_reach)  stuck_d = 1'b1;
    if (clr)       stuck_d = 1'b0;
  end

  // Glitch count and stuck flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_q <= '0;
      stuck_q  <= 1'b0;
    end else begin
      glitch_q <= glitch_d;
      stuck_q  <= stuck_d;
    end
  end

  assign level       = level_q;
  assign rise        = rise_q;
  assign fall        = fall_q;
  assign width       = width_q;
  assign width_valid = width_valid_q;
  assign glitch_cnt  = glitch_q;
  assign stuck       = stuck_q;

endmodule

// File: tb/tb_od_receiver.sv
// Bench for od_receiver: sliding-window reference model checked every cycle,
// plus hand-computed latency, width, glitch and stuck expectations.
module tb_od_receiver;

  localparam int SYNC  = 2;
  localparam int FILT  = 3;
  localparam int WB    = 8;
  localparam int STUCK = 20;
  localparam int WMAX  = (1 << WB) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic node = 1'b1;
  logic clr = 1'b0;
  logic level, rise, fall, width_valid, stuck;
  logic [WB-1:0] width, glitch_cnt;

  int vectors = 0;
  int miscompares = 0;

  od_receiver #(
    .SYNC_STAGES (SYNC),
    .FILTER      (FILT),
    .WIDTH_BITS  (WB),
    .STUCK_CYCLES(STUCK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .node       (node),
    .clr        (clr),
    .level      (level),
    .rise       (rise),
    .fall       (fall),
    .width      (width),
    .width_valid(width_valid),
    .glitch_cnt (glitch_cnt),
    .stuck      (stuck)
  );

  always #5 clk = ~clk;

  // Reference model: node delayed by the synchronizer depth, level flips when
  // the last FILT samples all disagree with it, times taken from a cycle count.
  bit nq[$];
  bit win[$];
  bit prev_s = 1'b1;
  bit m_level = 1'b1, m_rise = 1'b0, m_fall = 1'b0, m_wv = 1'b0, m_stuck = 1'b0;
  bit rise_seen = 1'b0;
  int m_width = 0, m_glitch = 0;
  int cyc = 0, cyc_rise = 0, cyc_fall = 0;

  task automatic model_reset();
    nq.delete();
    repeat (SYNC) nq.push_back(1'b1);
    win.delete();
    repeat (FILT) win.push_back(1'b1);
    prev_s = 1'b1;
    m_level = 1'b1; m_rise = 1'b0; m_fall = 1'b0; m_wv = 1'b0; m_stuck = 1'b0;
    rise_seen = 1'b0;
    m_width = 0; m_glitch = 0;
    cyc = 0; cyc_rise = 0; cyc_fall = 0;
  endtask

  task automatic model_step();
    bit s, old_lvl, commit, gev;
    cyc++;
    s = nq.pop_front();
    nq.push_back(node);
    old_lvl = m_level;
    win.push_back(s);
    void'(win.pop_front());
    commit = 1'b1;
    foreach (win[i]) if (win[i] == old_lvl) commit = 1'b0;
    gev = !commit && (s == old_lvl) && (prev_s != old_lvl);
    prev_s = s;
    m_rise = commit && !old_lvl;
    m_fall = commit && old_lvl;
    m_wv   = m_fall;
    if (m_rise) begin
      rise_seen = 1'b1;
      cyc_rise = cyc;
    end
    if (m_fall) begin
      m_width = !rise_seen ? 0 : ((cyc - cyc_rise) > WMAX ? WMAX : cyc - cyc_rise);
      cyc_fall = cyc;
    end
    if (m_rise) m_stuck = 1'b0;
    else if (!old_lvl && (cyc - cyc_fall) == STUCK) m_stuck = 1'b1;
    if (clr) m_stuck = 1'b0;
    if (clr) m_glitch = 0;
    else if (gev && m_glitch < WMAX) m_glitch++;
    if (commit) m_level = !old_lvl;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      check("level", int'(level), int'(m_level));
      check("rise", int'(rise), int'(m_rise));
      check("fall", int'(fall), int'(m_fall));
      check("width_valid", int'(width_valid), int'(m_wv));
      check("width", int'(width), m_width);
      check("glitch_cnt", int'(glitch_cnt), m_glitch);
      check("stuck", int'(stuck), int'(m_stuck));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic bit sig(input int which);
    case (which)
      0:       return rise;
      1:       return fall;
      default: return stuck;
    endcase
  endfunction

  // Steps until the selected output is seen high, bounded by maxc cycles.
  task automatic wait_for(input int which, input int maxc, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!sig(which) && n < maxc);
  endtask

  localparam int RISE_S = 0, FALL_S = 1, STUCK_S = 2;

  initial begin
    int n;
    fork
      compare_loop();
    join_none

    // Reset state
    repeat (3) step();
    check("reset_level", int'(level), 1);
    check("reset_width", int'(width), 0);
    check("reset_glitch", int'(glitch_cnt), 0);
    check("reset_stuck", int'(stuck), 0);
    check("reset_fall", int'(fall), 0);

    // Node held low straight out of reset
    rst_n = 1'b1;
    node  = 1'b0;
    wait_for(FALL_S, 20, n);
    check("fall_after_reset_latency", n, 5);
    check("fall_after_reset_width", int'(width), 0);
    check("fall_after_reset_wv", int'(width_valid), 1);

    // Clean 10-cycle pulse
    repeat (5) step();
    node = 1'b1;
    wait_for(RISE_S, 20, n);
    check("rise_latency", n, 5);
    repeat (5) step();
    node = 1'b0;
    wait_for(FALL_S, 20, n);
    check("fall_latency", n, 5);
    check("pulse_width", int'(width), 10);
    check("pulse_wv", int'(width_valid), 1);

    // Stuck low, clear, re-arm only after a rise
    wait_for(STUCK_S, 40, n);
    check("stuck_after_fall", n, 20);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("stuck_cleared", int'(stuck), 0);
    repeat (30) step();
    check("stuck_stays_clear", int'(stuck), 0);
    node = 1'b1;
    repeat (10) step();
    node = 1'b0;
    wait_for(FALL_S, 20, n);
    check("refall_latency", n, 5);
    wait_for(STUCK_S, 40, n);
    check("stuck_rearmed", n, 20);

    // Two-cycle low glitches inside a high period
    node = 1'b1;
    repeat (10) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 300; i++) begin
      node = 1'b0;
      repeat (2) step();
      node = 1'b1;
      repeat (6) step();
      if (i == 0) begin
        check("glitch_one", int'(glitch_cnt), 1);
        check("glitch_level_held", int'(level), 1);
      end
    end
    check("glitch_saturated", int'(glitch_cnt), 255);

    // clr in the same cycle as a rejected transition
    node = 1'b0;
    repeat (2) step();
    node = 1'b1;
    repeat (2) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_beats_glitch", int'(glitch_cnt), 0);
    repeat (6) step();

    // 400-cycle high pulse saturates width
    node = 1'b0;
    wait_for(FALL_S, 20, n);
    check("pre_long_fall", n, 5);
    repeat (5) step();
    node = 1'b1;
    wait_for(RISE_S, 20, n);
    check("long_rise", n, 5);
    repeat (395) step();
    node = 1'b0;
    wait_for(FALL_S, 20, n);
    check("long_fall", n, 5);
    check("long_width", int'(width), 255);

    // Reset during QUAL_LOW
    node = 1'b1;
    repeat (20) step();
    node = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    repeat (3) step();
    check("midreset_level", int'(level), 1);
    check("midreset_fall", int'(fall), 0);
    check("midreset_wv", int'(width_valid), 0);
    check("midreset_width", int'(width), 0);
    check("midreset_glitch", int'(glitch_cnt), 0);
    node  = 1'b1;
    rst_n = 1'b1;
    repeat (20) step();
    check("post_reset_level", int'(level), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
